// File: rtl/afifo_pkg.sv
// Shared definitions for the async-FIFO read-side bridge: FSM encoding and buffer sizing.
package afifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } bridge_state_e;

    localparam int unsigned BRIDGE_BUF_DEEP = 2;
    localparam int unsigned BRIDGE_OCC_W    = $clog2(BRIDGE_BUF_DEEP + 1);
    localparam int unsigned BRIDGE_PEND_W   = BRIDGE_OCC_W + 1;
    localparam int unsigned BRIDGE_CNT_W    = 8;

endpackage

// File: rtl/afifo_rd_skid.sv
// Two-entry in-order buffer between the FIFO read data and the output stream.
module afifo_rd_skid
    import afifo_pkg::*;
#(
    parameter int unsigned BITWID = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [BITWID-1:0]       wr_dat,
    input  logic                    rd,
    output logic [BITWID-1:0]       rd_dat,
    output logic [BRIDGE_OCC_W-1:0] occ
);

    logic [BITWID-1:0] mem [BRIDGE_BUF_DEEP];
    logic              wptr;
    logic              rptr;
    logic              do_wr;
    logic              do_rd;

    // A write into a full buffer is only accepted when the same cycle frees a slot.
    assign do_rd = rd && (occ != '0);
    assign do_wr = wr && ((occ != BRIDGE_OCC_W'(BRIDGE_BUF_DEEP)) || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BRIDGE_BUF_DEEP; i++) begin
                mem[i] <= '0;
            end
            wptr <= 1'b0;
            rptr <= 1'b0;
            occ  <= '0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= wr_dat;
                wptr      <= ~wptr;
            end
            if (do_rd) begin
                rptr <= ~rptr;
            end
            case ({do_wr, do_rd})
                2'b10:   occ <= occ + BRIDGE_OCC_W'(1);
                2'b01:   occ <= occ - BRIDGE_OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign rd_dat = mem[rptr];

endmodule

// File: rtl/afifo_rd_bridge.sv
// Drains an async FIFO read port into a valid/ready stream with packet framing.
// Optional: define AFIFO_RD_BRIDGE_LAST_EN to build the beat counter and m_last.
module afifo_rd_bridge
    import afifo_pkg::*;
#(
    parameter int unsigned DEEPWID = 3,
    parameter int unsigned BITWID  = 8
) (
    input  logic               rd_clk,
    input  logic               rd_rst_n,
    input  logic               cfg_en,
    input  logic [7:0]         cfg_pkt_len,
    input  logic [DEEPWID:0]   fifo_rd_num,
    output logic               fifo_rd,
    input  logic [BITWID-1:0]  fifo_rd_dat,
    input  logic               fifo_rd_dat_vld,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BITWID-1:0]  m_dat,
    output logic               m_last,
    output logic               busy
);

    bridge_state_e             state;
    logic                      inflight;
    logic [BRIDGE_OCC_W-1:0]   occ;
    logic [BRIDGE_PEND_W-1:0]  pending;
    logic                      pop;
    logic                      drained;
    logic                      to_idle;

    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;

    // Words already owned by the bridge after this cycle's pop; reads stop at buffer depth.
    assign pending = BRIDGE_PEND_W'(occ) + BRIDGE_PEND_W'(inflight) - BRIDGE_PEND_W'(pop);
    assign fifo_rd = (state == RUN) && (fifo_rd_num != '0)
                     && (pending < BRIDGE_PEND_W'(BRIDGE_BUF_DEEP));

    // Nothing in flight and the buffer empties at this edge.
    assign drained = !inflight && !fifo_rd_dat_vld && (occ == BRIDGE_OCC_W'(pop));
    assign to_idle = (state == STOP) && drained;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd;
            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!cfg_en) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (drained) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    afifo_rd_skid #(
        .BITWID (BITWID)
    ) u_skid (
        .clk    (rd_clk),
        .rst_n  (rd_rst_n),
        .wr     (fifo_rd_dat_vld),
        .wr_dat (fifo_rd_dat),
        .rd     (pop),
        .rd_dat (m_dat),
        .occ    (occ)
    );

`ifdef AFIFO_RD_BRIDGE_LAST_EN
    logic [BRIDGE_CNT_W-1:0] cnt;

    // Length 0 wraps to 255, giving 256-beat packets.
    assign m_last = m_valid && (cnt == (cfg_pkt_len - 8'd1));

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            cnt <= '0;
        end else if (to_idle || (state == IDLE)) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= m_last ? '0 : cnt + BRIDGE_CNT_W'(1);
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{cfg_pkt_len, to_idle};
    assign m_last     = 1'b0;
`endif

endmodule

// File: tb/tb_afifo_rd_bridge.sv
// Directed self-checking bench for afifo_rd_bridge with a simple upstream FIFO model.
`timescale 1ns/1ps
module tb_afifo_rd_bridge;

    localparam int unsigned DEEPWID  = 3;
    localparam int unsigned BITWID   = 8;
    localparam int unsigned FIFO_CAP = 1 << DEEPWID;
`ifdef AFIFO_RD_BRIDGE_LAST_EN
    localparam bit LAST_ON = 1'b1;
`else
    localparam bit LAST_ON = 1'b0;
`endif

    logic               rd_clk = 1'b0;
    logic               rd_rst_n;
    logic               cfg_en;
    logic [7:0]         cfg_pkt_len;
    logic [DEEPWID:0]   fifo_rd_num = '0;
    logic               fifo_rd;
    logic [BITWID-1:0]  fifo_rd_dat = '0;
    logic               fifo_rd_dat_vld = 1'b0;
    logic               m_valid;
    logic               m_ready;
    logic [BITWID-1:0]  m_dat;
    logic               m_last;
    logic               busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ovf_cnt = 0;
    int up_n;
    logic rd_seen = 1'b0;

    logic [BITWID-1:0] up_q[$];
    int                rd_log[$];
    logic [BITWID-1:0] dat_log[$];
    logic              last_log[$];
    int                pop_cyc[$];

    afifo_rd_bridge #(
        .DEEPWID (DEEPWID),
        .BITWID  (BITWID)
    ) dut (
        .rd_clk          (rd_clk),
        .rd_rst_n        (rd_rst_n),
        .cfg_en          (cfg_en),
        .cfg_pkt_len     (cfg_pkt_len),
        .fifo_rd_num     (fifo_rd_num),
        .fifo_rd         (fifo_rd),
        .fifo_rd_dat     (fifo_rd_dat),
        .fifo_rd_dat_vld (fifo_rd_dat_vld),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_dat           (m_dat),
        .m_last          (m_last),
        .busy            (busy)
    );

    always #5 rd_clk = ~rd_clk;

    // Upstream FIFO: data and valid one cycle after the pop strobe; readable count is capped.
    always @(posedge rd_clk) begin
        cyc++;
        if (rd_seen && (up_q.size() > 0)) begin
            fifo_rd_dat     <= up_q.pop_front();
            fifo_rd_dat_vld <= 1'b1;
        end else begin
            fifo_rd_dat_vld <= 1'b0;
        end
        up_n = up_q.size();
        fifo_rd_num <= (up_n > int'(FIFO_CAP)) ? (DEEPWID+1)'(FIFO_CAP) : (DEEPWID+1)'(up_n);
    end

    always @(negedge rd_clk) begin
        rd_seen = fifo_rd;
        if (fifo_rd) rd_log.push_back(cyc);
        if (m_valid && m_ready) begin
            dat_log.push_back(m_dat);
            last_log.push_back(m_last);
            pop_cyc.push_back(cyc);
        end
        if (fifo_rd_dat_vld && (dut.u_skid.occ == 2'd2) && !(m_valid && m_ready)) ovf_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) up_q.push_back(8'(base + 8'(i)));
    endtask

    task automatic go_idle();
        int k;
        cfg_en = 1'b0;
        k = 0;
        while (busy && k < 50) begin tick(); k++; end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL go_idle_timeout: busy=%0b want 0", busy);
        end
        up_q.delete();
        tick(2);
    endtask

    task automatic test_reset();
        rd_rst_n = 1'b0; cfg_en = 1'b0; m_ready = 1'b0; cfg_pkt_len = 8'd0;
        tick(3);
        @(negedge rd_clk);
        tests += 5;
        if (fifo_rd !== 1'b0) begin fails++; $display("FAIL rst_fifo_rd: got %b want 0", fifo_rd); end
        if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        if (m_dat !== 8'h00)  begin fails++; $display("FAIL rst_m_dat: got %h want 00", m_dat); end
        if (m_last !== 1'b0)  begin fails++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        if (busy !== 1'b0)    begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tick();
        rd_rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_stream();
        int rb = rd_log.size();
        int db = dat_log.size();
        int k = 0;
        cfg_pkt_len = 8'd0; m_ready = 1'b1;
        push(5, 8'h10);
        cfg_en = 1'b1;
        while ((dat_log.size() - db) < 5 && k < 30) begin tick(); k++; end
        tick(3);
        tests++;
        if (rd_log.size() - rb != 5) begin
            fails++; $display("FAIL stream_rd_count: got %0d want 5", rd_log.size() - rb);
        end
        if (rd_log.size() - rb >= 5 && dat_log.size() - db >= 5) begin
            tests += 3;
            if (rd_log[rb+4] - rd_log[rb] != 4) begin
                fails++; $display("FAIL stream_rd_consec: span %0d want 4", rd_log[rb+4] - rd_log[rb]);
            end
            if (pop_cyc[db] != rd_log[rb] + 2) begin
                fails++; $display("FAIL stream_latency: first beat cyc %0d want %0d", pop_cyc[db], rd_log[rb] + 2);
            end
            if (pop_cyc[db+4] - pop_cyc[db] != 4) begin
                fails++; $display("FAIL stream_beat_consec: span %0d want 4", pop_cyc[db+4] - pop_cyc[db]);
            end
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (dat_log[db+i] !== 8'(8'h10 + 8'(i)) || last_log[db+i] !== 1'b0) begin
                    fails++;
                    $display("FAIL stream_beat%0d: got %h/%b want %h/0", i, dat_log[db+i], last_log[db+i], 8'(8'h10 + 8'(i)));
                end
            end
        end
        go_idle();
    endtask

    task automatic test_backpressure();
        int rb = rd_log.size();
        int db = dat_log.size();
        int k = 0;
        m_ready = 1'b0;
        push(4, 8'h20);
        cfg_en = 1'b1;
        tick(8);
        @(negedge rd_clk);
        tests += 4;
        if (rd_log.size() - rb != 2) begin fails++; $display("FAIL bp_rd_count: got %0d want 2", rd_log.size() - rb); end
        if (fifo_rd !== 1'b0)        begin fails++; $display("FAIL bp_fifo_rd: got %b want 0", fifo_rd); end
        if (m_valid !== 1'b1)        begin fails++; $display("FAIL bp_m_valid: got %b want 1", m_valid); end
        if (m_dat !== 8'h20)         begin fails++; $display("FAIL bp_m_dat: got %h want 20", m_dat); end
        tick(3);
        @(negedge rd_clk);
        tests += 2;
        if (m_dat !== 8'h20)         begin fails++; $display("FAIL bp_m_dat_hold: got %h want 20", m_dat); end
        if (rd_log.size() - rb != 2) begin fails++; $display("FAIL bp_rd_hold: got %0d want 2", rd_log.size() - rb); end
        tick();
        m_ready = 1'b1;
        while ((dat_log.size() - db) < 4 && k < 20) begin tick(); k++; end
        tick(3);
        tests += 2;
        if (rd_log.size() - rb != 4)  begin fails++; $display("FAIL bp_rd_total: got %0d want 4", rd_log.size() - rb); end
        if (dat_log.size() - db != 4) begin fails++; $display("FAIL bp_beat_total: got %0d want 4", dat_log.size() - db); end
        for (int i = 0; i < 4 && (db + i) < dat_log.size(); i++) begin
            tests++;
            if (dat_log[db+i] !== 8'(8'h20 + 8'(i))) begin
                fails++; $display("FAIL bp_beat%0d: got %h want %h", i, dat_log[db+i], 8'(8'h20 + 8'(i)));
            end
        end
        go_idle();
    endtask

    task automatic test_last();
        int db = dat_log.size();
        int k = 0;
        int nlast = 0;
        int ilast = -1;
        int bad = 0;
        logic [6:0] lv = '0;
        logic [6:0] lv_exp;
        m_ready = 1'b1; cfg_pkt_len = 8'd3;
        push(7, 8'h40);
        cfg_en = 1'b1;
        while ((dat_log.size() - db) < 7 && k < 30) begin tick(); k++; end
        for (int i = 0; i < 7 && (db + i) < last_log.size(); i++) lv[i] = last_log[db+i];
        lv_exp = LAST_ON ? 7'b0100100 : 7'b0000000;
        tests++;
        if (lv !== lv_exp) begin fails++; $display("FAIL last_len3: got %b want %b", lv, lv_exp); end
        go_idle();

        db = dat_log.size();
        k = 0;
        cfg_pkt_len = 8'd0;
        for (int i = 0; i < 300; i++) up_q.push_back(8'(i));
        cfg_en = 1'b1;
        while ((dat_log.size() - db) < 300 && k < 500) begin tick(); k++; end
        for (int i = 0; i < 300 && (db + i) < dat_log.size(); i++) begin
            if (last_log[db+i] === 1'b1) begin nlast++; ilast = i; end
            if (dat_log[db+i] !== 8'(i)) bad++;
        end
        tests += 4;
        if (dat_log.size() - db != 300) begin fails++; $display("FAIL last256_beats: got %0d want 300", dat_log.size() - db); end
        if (nlast != (LAST_ON ? 1 : 0)) begin fails++; $display("FAIL last256_count: got %0d want %0d", nlast, LAST_ON ? 1 : 0); end
        if (ilast != (LAST_ON ? 255 : -1)) begin fails++; $display("FAIL last256_index: got %0d want %0d", ilast, LAST_ON ? 255 : -1); end
        if (bad != 0) begin fails++; $display("FAIL last256_data: %0d bad beats want 0", bad); end
        go_idle();
    endtask

    task automatic test_stop();
        int rb = rd_log.size();
        int db = dat_log.size();
        int k = 0;
        m_ready = 1'b0;
        push(4, 8'h50);
        cfg_en = 1'b1;
        while ((rd_log.size() - rb) < 2 && k < 20) begin tick(); k++; end
        cfg_en = 1'b0;
        @(negedge rd_clk);
        tests += 2;
        if (m_valid !== 1'b1) begin fails++; $display("FAIL stop_occ1_valid: got %b want 1", m_valid); end
        if (fifo_rd !== 1'b0) begin fails++; $display("FAIL stop_no_rd: got %b want 0", fifo_rd); end
        tick(3);
        @(negedge rd_clk);
        tests += 2;
        if (rd_log.size() - rb != 2) begin fails++; $display("FAIL stop_rd_count: got %0d want 2", rd_log.size() - rb); end
        if (busy !== 1'b1)           begin fails++; $display("FAIL stop_busy_hold: got %b want 1", busy); end
        tick();
        m_ready = 1'b1;
        k = 0;
        while ((dat_log.size() - db) < 2 && k < 20) begin tick(); k++; end
        @(negedge rd_clk);
        tests += 2;
        if (busy !== 1'b0) begin fails++; $display("FAIL stop_busy_clear: got %b want 0", busy); end
        if (dat_log.size() - db != 2) begin
            fails++; $display("FAIL stop_beats: got %0d want 2", dat_log.size() - db);
        end else begin
            tests += 2;
            if (pop_cyc[db+1] != cyc - 1) begin
                fails++; $display("FAIL stop_busy_timing: last pop cyc %0d want %0d", pop_cyc[db+1], cyc - 1);
            end
            if (dat_log[db] !== 8'h50 || dat_log[db+1] !== 8'h51) begin
                fails++; $display("FAIL stop_data: got %h %h want 50 51", dat_log[db], dat_log[db+1]);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_midpkt();
        int rb;
        int db = dat_log.size();
        int k = 0;
        logic [2:0] lv = '0;
        logic [2:0] lv_exp;
        m_ready = 1'b1; cfg_pkt_len = 8'd3;
        push(6, 8'h60);
        cfg_en = 1'b1;
        while ((dat_log.size() - db) < 1 && k < 20) begin tick(); k++; end
        m_ready = 1'b0;
        tick(4);
        @(negedge rd_clk);
        tests += 2;
        if (m_valid !== 1'b1 || dut.u_skid.occ !== 2'd2) begin
            fails++; $display("FAIL rmid_full: valid=%b occ=%0d want 1/2", m_valid, dut.u_skid.occ);
        end
        if (dat_log.size() - db != 1) begin fails++; $display("FAIL rmid_one_beat: got %0d want 1", dat_log.size() - db); end
        tick();
        rb = rd_log.size();
        rd_rst_n = 1'b0;
        cfg_en = 1'b0;
        #1;
        tests += 4;
        if (m_valid !== 1'b0) begin fails++; $display("FAIL rmid_m_valid: got %b want 0", m_valid); end
        if (busy !== 1'b0)    begin fails++; $display("FAIL rmid_busy: got %b want 0", busy); end
        if (fifo_rd !== 1'b0) begin fails++; $display("FAIL rmid_fifo_rd: got %b want 0", fifo_rd); end
        if (m_last !== 1'b0)  begin fails++; $display("FAIL rmid_m_last: got %b want 0", m_last); end
        up_q.delete();
        tick(3);
        tests++;
        if (rd_log.size() != rb) begin fails++; $display("FAIL rmid_rd_in_reset: got %0d want 0", rd_log.size() - rb); end
        rd_rst_n = 1'b1;
        tick();
        db = dat_log.size();
        k = 0;
        m_ready = 1'b1;
        push(3, 8'h70);
        cfg_en = 1'b1;
        while ((dat_log.size() - db) < 3 && k < 20) begin tick(); k++; end
        for (int i = 0; i < 3 && (db + i) < last_log.size(); i++) lv[i] = last_log[db+i];
        lv_exp = LAST_ON ? 3'b100 : 3'b000;
        tests += 2;
        if (lv !== lv_exp) begin fails++; $display("FAIL rmid_restart_last: got %b want %b", lv, lv_exp); end
        if (dat_log.size() - db != 3 || dat_log[db] !== 8'h70) begin
            fails++; $display("FAIL rmid_restart_data: beats %0d want 3 starting 70", dat_log.size() - db);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_last();
        test_stop();
        test_reset_midpkt();
        tests++;
        if (ovf_cnt != 0) begin fails++; $display("FAIL buffer_overflow: got %0d events want 0", ovf_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
